relm_div_seq: RTL and testbench

Multi-cycle sequencer for unsigned 32-bit integer division by radix-4 restoring steps, two quotient bits per cycle. It is a standalone coprocessor beside the ReLM core, used when the custom datapath is busy with floating-point work. Requests and responses use valid/ready handshakes. Latency scales with the bit-length difference between numerator and divisor.

---
 rtl/relm_div_pkg.sv | 37 +++
 rtl/relm_div_step.sv | 30 +++
 rtl/relm_div_seq.sv | 180 ++++++++++++++++++
 tb/tb_relm_div_seq.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/relm_div_pkg.sv
// Shared types, constants and helpers for the relm_div_seq radix-4 divider.
// The optional signed mode is enabled with `define RELM_DIV_SIGNED_EN.
package relm_div_pkg;

   localparam int WD = 32;
   localparam logic [WD-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE,
      INIT,
      LOOP,
      DONE
   } state_t;

   // Keep only the most significant set bit of x. Zero input gives zero.
   function automatic logic [WD-1:0] lead_one_mask(input logic [WD-1:0] x);
      logic [WD-1:0] s;
      s = x;
      s = s | (s >> 1);
      s = s | (s >> 2);
      s = s | (s >> 4);
      s = s | (s >> 8);
      s = s | (s >> 16);
      return s ^ (s >> 1);
   endfunction

   // Bit index of a one-hot vector. A zero vector maps to index 0.
   function automatic logic [4:0] onehot_index(input logic [WD-1:0] oh);
      logic [4:0] idx;
      idx = '0;
      for (int i = 0; i < WD; i++) begin
         if (oh[i]) idx = idx | 5'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/relm_div_step.sv
// One radix-4 restoring step: retires up to two quotient bits, q and q>>1.
// Purely combinational; the sequencer registers every output.
module relm_div_step
   import relm_div_pkg::*;
(
   input  logic [WD-1:0] n,
   input  logic [WD-1:0] dq,
   input  logic [WD-1:0] q,
   output logic [WD-1:0] n_next,
   output logic [WD-1:0] q_bits,
   output logic          last
);

   logic [WD-1:0] dq_half;
   logic [WD-1:0] n_mid;
   logic          take_hi;
   logic          take_lo;

   always_comb begin
      dq_half = dq >> 1;
      take_hi = (dq <= n);
      n_mid   = take_hi ? n - dq : n;
      // When q[0] is set the divisor is unshifted, so there is no lower half-step.
      take_lo = !q[0] && (dq_half <= n_mid);
      n_next  = take_lo ? n_mid - dq_half : n_mid;
      q_bits  = (take_hi ? q : '0) | (take_lo ? (q >> 1) : '0);
      last    = |q[1:0];
   end

endmodule

// File: rtl/relm_div_seq.sv
// Sequenced 32-bit divider, two quotient bits per LOOP cycle, valid/ready on both sides.
// Define RELM_DIV_SIGNED_EN to honour req_signed (truncating two's-complement division).
module relm_div_seq
   import relm_div_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [WD-1:0] req_n,
   input  logic [WD-1:0] req_d,
   input  logic          req_signed,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [WD-1:0] rsp_q,
   output logic [WD-1:0] rsp_r,
   output logic          rsp_div0,
   output logic          busy
);

   state_t        state;
   state_t        state_nxt;

   logic [WD-1:0] n_work;
   logic [WD-1:0] d_reg;
   logic [WD-1:0] q_acc;
   logic [WD-1:0] q_bit;
   logic [WD-1:0] dq;
   logic          neg_q;
   logic          neg_r;

   logic [WD-1:0] res_q;
   logic [WD-1:0] res_r;
   logic          res_div0;

   logic          accept;
   logic          load_result;
   logic [4:0]    msb_n;
   logic [4:0]    msb_d;
   logic [4:0]    shamt;
   logic          is_div0;
   logic          trivial;

   logic [WD-1:0] step_n;
   logic [WD-1:0] step_q;
   logic          step_last;

   logic [WD-1:0] raw_q;
   logic [WD-1:0] raw_r;
   logic          raw_div0;
   logic [WD-1:0] fin_q;
   logic [WD-1:0] fin_r;

   relm_div_step u_step (
      .n      (n_work),
      .dq     (dq),
      .q      (q_bit),
      .n_next (step_n),
      .q_bits (step_q),
      .last   (step_last)
   );

   assign accept = req_valid && req_ready;

   always_comb begin
      msb_n   = onehot_index(lead_one_mask(n_work));
      msb_d   = onehot_index(lead_one_mask(d_reg));
      shamt   = msb_n - msb_d;
      is_div0 = (d_reg == '0);
      trivial = is_div0 || (n_work == '0) || (msb_n < msb_d);
   end

   // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_nxt   = state;
      load_result = 1'b0;
      case (state)
         IDLE: if (accept) state_nxt = INIT;
         INIT: begin
            if (trivial) begin
               state_nxt   = DONE;
               load_result = 1'b1;
            end else begin
               state_nxt = LOOP;
            end
         end
         LOOP: begin
            if (step_last) begin
               state_nxt   = DONE;
               load_result = 1'b1;
            end
         end
         DONE: if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Result as it will appear in DONE; INIT only ever loads the trivial cases.
   always_comb begin
      raw_q    = q_acc | step_q;
      raw_r    = step_n;
      raw_div0 = 1'b0;
      if (state == INIT) begin
         raw_q    = is_div0 ? DIV0_QUOTIENT : '0;
         raw_r    = n_work;
         raw_div0 = is_div0;
      end
      fin_q = (neg_q && !raw_div0) ? -raw_q : raw_q;
      fin_r = neg_r ? -raw_r : raw_r;
   end

   // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         n_work   <= '0;
         d_reg    <= '0;
         q_acc    <= '0;
         q_bit    <= '0;
         dq       <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         res_q    <= '0;
         res_r    <= '0;
         res_div0 <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  q_acc <= '0;
`ifdef RELM_DIV_SIGNED_EN
                  n_work <= (req_signed && req_n[WD-1]) ? -req_n : req_n;
                  d_reg  <= (req_signed && req_d[WD-1]) ? -req_d : req_d;
                  neg_q  <= req_signed && (req_n[WD-1] ^ req_d[WD-1]);
                  neg_r  <= req_signed && req_n[WD-1];
`else
                  n_work <= req_n;
                  d_reg  <= req_d;
                  neg_q  <= 1'b0;
                  neg_r  <= 1'b0;
`endif
               end
            end
            INIT: begin
               q_bit <= WD'(1) << shamt;
               dq    <= d_reg << shamt;
            end
            LOOP: begin
               n_work <= step_n;
               q_acc  <= q_acc | step_q;
               q_bit  <= q_bit >> 2;
               dq     <= dq >> 2;
            end
            default: ;
         endcase
         if (load_result) begin
            res_q    <= fin_q;
            res_r    <= fin_r;
            res_div0 <= raw_div0;
         end
      end
   end

`ifndef RELM_DIV_SIGNED_EN
   logic unused_signed;
   assign unused_signed = req_signed;
`endif

   assign req_ready = (state == IDLE) && rst_n;
   assign rsp_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign rsp_q     = res_q;
   assign rsp_r     = res_r;
   assign rsp_div0  = res_div0;

endmodule

// File: tb/tb_relm_div_seq.sv
// Self-checking bench for relm_div_seq: expected results are queued at request time
// and compared when rsp_valid appears. Works with or without RELM_DIV_SIGNED_EN.
module tb_relm_div_seq;

   typedef struct {
      string       name;
      logic [31:0] q;
      logic [31:0] r;
      logic        div0;
      int          lat;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_n;
   logic [31:0] req_d;
   logic        req_signed;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_q;
   logic [31:0] rsp_r;
   logic        rsp_div0;
   logic        busy;

   int   passed;
   int   total;
   exp_t sb[$];

   relm_div_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_n      (req_n),
      .req_d      (req_d),
      .req_signed (req_signed),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_q      (rsp_q),
      .rsp_r      (rsp_r),
      .rsp_div0   (rsp_div0),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic int msb_idx(input logic [31:0] x);
      int m;
      m = -1;
      for (int i = 0; i < 32; i++) if (x[i]) m = i;
      return m;
   endfunction

   function automatic exp_t model(input string name, input logic [31:0] n, input logic [31:0] d,
                                  input logic sgn);
      exp_t        e;
      logic [31:0] an;
      logic [31:0] ad;
      logic        sn;
      logic        sd;
      int          mn;
      int          md;
      sn = 1'b0;
      sd = 1'b0;
      e.name = sgn ? {name, "(s)"} : name;
`ifdef RELM_DIV_SIGNED_EN
      if (sgn) begin
         sn = n[31];
         sd = d[31];
      end
`endif
      an = sn ? -n : n;
      ad = sd ? -d : d;
      if (ad == 32'd0) begin
         e.q    = 32'hFFFF_FFFF;
         e.r    = n;
         e.div0 = 1'b1;
         e.lat  = 2;
      end else begin
         e.q    = an / ad;
         e.r    = an % ad;
         e.div0 = 1'b0;
         if (sn ^ sd) e.q = -e.q;
         if (sn) e.r = -e.r;
         mn = msb_idx(an);
         md = msb_idx(ad);
         if (an == 32'd0 || mn < md) e.lat = 2;
         else e.lat = 2 + (mn - md + 2) / 2;
      end
      return e;
   endfunction

   // Issue one request, check latency and result, optionally stall rsp_ready, then retire it.
   task automatic run_one(input string name, input logic [31:0] n, input logic [31:0] d,
                          input logic sgn, input int hold);
      exp_t e;
      int   lat;
      e = model(name, n, d, sgn);
      sb.push_back(e);
      total++;
      if (req_ready !== 1'b1) $display("FAIL %s/ready_idle: got %b want 1", e.name, req_ready);
      else passed++;
      req_valid  = 1'b1;
      req_n      = n;
      req_d      = d;
      req_signed = sgn;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_n     = $urandom;
      req_d     = $urandom;
      total++;
      if (busy !== 1'b1 || req_ready !== 1'b0)
         $display("FAIL %s/busy_after_accept: busy=%b req_ready=%b want 1,0", e.name, busy, req_ready);
      else passed++;
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      e = sb.pop_front();
      total++;
      if (rsp_valid !== 1'b1) begin
         $display("FAIL %s/timeout: rsp_valid=%b after %0d cycles, want 1", e.name, rsp_valid, lat);
         return;
      end
      passed++;
      total++;
      if (lat !== e.lat) $display("FAIL %s/latency: got %0d want %0d", e.name, lat, e.lat);
      else passed++;
      total++;
      if (rsp_q !== e.q) $display("FAIL %s/q: got %h want %h", e.name, rsp_q, e.q);
      else passed++;
      total++;
      if (rsp_r !== e.r) $display("FAIL %s/r: got %h want %h", e.name, rsp_r, e.r);
      else passed++;
      total++;
      if (rsp_div0 !== e.div0) $display("FAIL %s/div0: got %b want %b", e.name, rsp_div0, e.div0);
      else passed++;
      if (hold > 0) begin
         req_valid = 1'b1;
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            total++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_q !== e.q || rsp_r !== e.r ||
                rsp_div0 !== e.div0)
               $display("FAIL %s/hold%0d: valid=%b ready=%b q=%h r=%h div0=%b want 1,0,%h,%h,%b",
                        e.name, i, rsp_valid, req_ready, rsp_q, rsp_r, rsp_div0, e.q, e.r, e.div0);
            else passed++;
         end
         req_valid = 1'b0;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      total++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0)
         $display("FAIL %s/retire: valid=%b ready=%b busy=%b want 0,1,0", e.name, rsp_valid,
                  req_ready, busy);
      else passed++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_q !== 32'd0 ||
          rsp_r !== 32'd0 || rsp_div0 !== 1'b0)
         $display("FAIL reset/values: ready=%b valid=%b busy=%b q=%h r=%h div0=%b want all 0",
                  req_ready, rsp_valid, busy, rsp_q, rsp_r, rsp_div0);
      else passed++;
      rst_n = 1'b1;
      @(posedge clk); #1;
      total++;
      if (req_ready !== 1'b1 || busy !== 1'b0)
         $display("FAIL reset/release: ready=%b busy=%b want 1,0", req_ready, busy);
      else passed++;
   endtask

   task automatic test_basic();
      run_one("n100_d7", 32'd100, 32'd7, 1'b0, 0);
      run_one("max_d1", 32'hFFFF_FFFF, 32'd1, 1'b0, 0);
      run_one("same_msb", 32'd13, 32'd9, 1'b0, 0);
      run_one("exact", 32'd1_000_000, 32'd1000, 1'b0, 0);
   endtask

   task automatic test_trivial();
      run_one("n5_d9", 32'd5, 32'd9, 1'b0, 0);
      run_one("n0_d3", 32'd0, 32'd3, 1'b0, 0);
      run_one("div0", 32'd1234, 32'd0, 1'b0, 0);
   endtask

   task automatic test_random();
      logic [31:0] n;
      logic [31:0] d;
      for (int i = 0; i < 8; i++) begin
         n = $urandom;
         d = $urandom >> $urandom_range(0, 31);
         run_one("rand", n, d, 1'b0, 0);
      end
   endtask

   task automatic test_hold();
      run_one("hold_n100_d7", 32'd100, 32'd7, 1'b0, 10);
   endtask

   task automatic test_reset_mid_loop();
      req_valid  = 1'b1;
      req_n      = 32'hFFFF_FFFF;
      req_d      = 32'd1;
      req_signed = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      total++;
      if (busy !== 1'b1 || rsp_valid !== 1'b0)
         $display("FAIL midreset/in_loop: busy=%b valid=%b want 1,0", busy, rsp_valid);
      else passed++;
      rst_n = 1'b0;
      @(posedge clk); #1;
      total++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b0 || rsp_q !== 32'd0 ||
          rsp_r !== 32'd0 || rsp_div0 !== 1'b0)
         $display("FAIL midreset/during: valid=%b busy=%b ready=%b q=%h r=%h div0=%b want 0,0,0,0,0,0",
                  rsp_valid, busy, req_ready, rsp_q, rsp_r, rsp_div0);
      else passed++;
      rst_n = 1'b1;
      @(posedge clk); #1;
      total++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
         $display("FAIL midreset/after: valid=%b ready=%b want 0,1", rsp_valid, req_ready);
      else passed++;
   endtask

   task automatic test_back_to_back();
      run_one("b2b_a", 32'd77, 32'd5, 1'b0, 0);
      run_one("b2b_b", 32'h8000_0000, 32'd3, 1'b0, 0);
      run_one("b2b_c", 32'd9, 32'd9, 1'b0, 0);
   endtask

   task automatic test_signed();
      run_one("neg7_d2", 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
      run_one("min_dm1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
      run_one("neg5_d0", 32'hFFFF_FFFB, 32'd0, 1'b1, 0);
      run_one("p20_dm3", 32'd20, 32'hFFFF_FFFD, 1'b1, 0);
   endtask

   initial begin
      passed     = 0;
      total      = 0;
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_n      = 32'd0;
      req_d      = 32'd0;
      req_signed = 1'b0;
      rsp_ready  = 1'b0;
      test_reset();
      test_basic();
      test_trivial();
      test_random();
      test_hold();
      test_reset_mid_loop();
      test_back_to_back();
      test_signed();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
